writeback_forward: RTL
======================

Name: writeback_forward

Overview:
- Back end of the datapath: registers execute results through the M (memory) and W (writeback) stages.
- Extracts and extends load data, drives the register-file write port, and produces the single forwarding pair (forward_ra/forward_rd) consumed by the operand-select logic in decode/execute.
- Holds load data across stalls so the synchronous data memory may change its output while M is frozen.

Parameters:
- DW, 32, datapath width.
- AW, 5, register address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  execute-stage instruction present.
- ex_reg_write  in  1  instruction writes a register.
- ex_mem_read  in  1  instruction is a load.
- ex_load_type  in  3  load kind (package encoding).
- ex_rd  in  AW  destination register.
- ex_result  in  DW  ALU result or load address.
- stall  in  1  freeze M stage.
- flush  in  1  discard the instruction entering M.
- dmem_rdata  in  DW  synchronous memory data, valid the cycle after the address is presented from X.
- forward_ra  out  AW  forwarded register number; 0 = none.
- forward_rd  out  DW  forwarded value.
- rf_we  out  1  register-file write enable.
- rf_wa  out  AW  write address.
- rf_wd  out  DW  write data.

Behaviour:
- Reset (async, rst_n=0): M and W valid cleared, hold state = RUN, all outputs 0. Mid-operation reset discards in-flight instructions, with no partial write.
- M register captures {valid, reg_write, mem_read, load_type, rd, result} each edge unless stall=1.
  - flush=1 (stall=0) captures a bubble (valid=0).
  - stall has priority: flush is ignored while stall=1.
- Load extraction (combinational, big-endian, byte 0 = [31:24]), using lo = M.result[1:0] and data = (hold state HELD ? held_data : dmem_rdata):
  - LW: data.
  - LB/LBU: byte lo, sign- or zero-extended.
  - LH/LHU: half lo[1] (lo[0] ignored), sign- or zero-extended.
- m_value = M.mem_read ? extracted : M.result.
- Hold FSM: states RUN and HELD.
  - RUN → HELD when stall=1 and M.valid & M.mem_read. On that edge, latch the extracted raw data into held_data.
  - HELD → RUN on the first edge with stall=0.
  - Otherwise remain in RUN.
- W register:
  - When stall=0, W captures {M.valid & M.reg_write & (M.rd≠0), M.rd, m_value}.
  - When stall=1, W captures a bubble, so an instruction writes exactly once.
- rf_we/rf_wa/rf_wd are driven directly from the W register; writeback latency is 2 cycles after X.
- Forwarding:
  - If M.valid & M.reg_write & M.rd≠0: forward_ra = M.rd, forward_rd = m_value.
  - Otherwise forward_ra = 0 and forward_rd = 0. forward_rd must be 0 whenever forward_ra = 0, so reads of $0 stay 0.
- Writes to $0 never assert rf_we.

Optional Feature:
- WB_FORWARD_EN defined:
  - When the M stage is not forwarding and rf_we=1, forward_ra = rf_wa and forward_rd = rf_wd.
  - M always has priority over W.
- Undefined: only the M stage forwards. The W hazard relies on the register file's write-first read.

Decomposition:
- Shared package `pipeline_pkg`:
  - load-type constants LT_W=0, LT_B=1, LT_BU=2, LT_H=3, LT_HU=4.
  - REG_ZERO=0.
  - Hold-state encoding.
- One natural sub-module: `load_extract` (combinational: data, lo, load_type → extended word).

Test Plan:
- ALU forward: ex_valid=1, reg_write=1, rd=8, result=0x12345678 → next cycle forward_ra=8, forward_rd=0x12345678; the cycle after, rf_we=1, rf_wa=8, rf_wd=0x12345678.
- Loads with dmem_rdata=0x8899AABB:
  - LB, addr lo=1 → 0xFFFFFF99.
  - LBU, lo=3 → 0x000000BB.
  - LH, lo=2 → 0xFFFFAABB.
  - LHU, lo=0 → 0x00008899.
  - LW → 0x8899AABB.
- Stall during load:
  - LW rd=9 in M, stall=1 for 3 cycles, dmem_rdata changes to 0xDEADBEEF after the first edge → forward_rd stays 0x8899AABB.
  - rf_we=0 during the stall; exactly one write of 0x8899AABB to r9 after release.
- $0 and flush:
  - rd=0 with reg_write=1 → forward_ra=0, forward_rd=0, rf_we never 1.
  - flush=1 with a valid instruction → no forward, no write.
  - flush=1 and stall=1 together → M unchanged.
- Reset mid-stream: rst_n low while M and W are valid → all outputs 0 immediately, no write after release.
- WB_FORWARD_EN:
  - Instruction to r5 followed by a bubble → with the macro, W forwards r5 on cycle 2.
  - With the macro, M instruction to r6 plus W write to r5 → forward_ra=6.
  - Without the macro, forward_ra=0 while r5 sits in W.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared constants for the back end of the pipeline:
// load-type encoding, the zero register, and the load-hold state encoding.
package pipeline_pkg;

    localparam logic [2:0] LT_W  = 3'd0;
    localparam logic [2:0] LT_B  = 3'd1;
    localparam logic [2:0] LT_BU = 3'd2;
    localparam logic [2:0] LT_H  = 3'd3;
    localparam logic [2:0] LT_HU = 3'd4;

    localparam int REG_ZERO = 0;

    localparam logic HS_RUN  = 1'b0;
    localparam logic HS_HELD = 1'b1;

endpackage

// File: rtl/load_extract.sv
// Big-endian load extraction (byte 0 = [31:24]).
// Ports: i_data raw word, i_lo address low bits, i_load_type, o_word result.
module load_extract
    import pipeline_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_data,
    input  logic [1:0]    i_lo,
    input  logic [2:0]    i_load_type,
    output logic [DW-1:0] o_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_data[DW-1 -: 8];
        case (i_lo)
            2'd1:    w_byte = i_data[DW-9  -: 8];
            2'd2:    w_byte = i_data[DW-17 -: 8];
            2'd3:    w_byte = i_data[DW-25 -: 8];
            default: w_byte = i_data[DW-1  -: 8];
        endcase
    end

    // Halfword select uses lo[1] only; lo[0] is ignored.
    assign w_half = i_lo[1] ? i_data[DW-17 -: 16] : i_data[DW-1 -: 16];

    always_comb begin
        o_word = i_data;
        unique case (i_load_type)
            LT_B:    o_word = {{(DW-8){w_byte[7]}}, w_byte};
            LT_BU:   o_word = {{(DW-8){1'b0}}, w_byte};
            LT_H:    o_word = {{(DW-16){w_half[15]}}, w_half};
            LT_HU:   o_word = {{(DW-16){1'b0}}, w_half};
            default: o_word = i_data;
        endcase
    end

endmodule

// File: rtl/writeback_forward.sv
// M/W pipeline registers, load extraction with stall hold, RF write port and forwarding.
// Ports: ex_* execute bundle, stall/flush, dmem_rdata in; forward_ra/rd, rf_we/wa/wd out.
// Optional: define WB_FORWARD_EN to also forward the W stage when M is not forwarding.
module writeback_forward
    import pipeline_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ex_valid,
    input  logic          ex_reg_write,
    input  logic          ex_mem_read,
    input  logic [2:0]    ex_load_type,
    input  logic [AW-1:0] ex_rd,
    input  logic [DW-1:0] ex_result,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] dmem_rdata,
    output logic [AW-1:0] forward_ra,
    output logic [DW-1:0] forward_rd,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd
);

    logic          r_m_valid;
    logic          r_m_reg_write;
    logic          r_m_mem_read;
    logic [2:0]    r_m_load_type;
    logic [AW-1:0] r_m_rd;
    logic [DW-1:0] r_m_result;

    logic          r_hold;
    logic [DW-1:0] r_held;

    logic          r_w_we;
    logic [AW-1:0] r_w_rd;
    logic [DW-1:0] r_w_wd;

    logic [DW-1:0] w_data;
    logic [DW-1:0] w_ext;
    logic [DW-1:0] w_m_value;
    logic          w_m_fwd;

    // Memory output may move while M is frozen, so use the held copy.
    assign w_data = (r_hold == HS_HELD) ? r_held : dmem_rdata;

    load_extract #(.DW(DW)) u_load_extract (
        .i_data      (w_data),
        .i_lo        (r_m_result[1:0]),
        .i_load_type (r_m_load_type),
        .o_word      (w_ext)
    );

    assign w_m_value = r_m_mem_read ? w_ext : r_m_result;
    assign w_m_fwd   = r_m_valid & r_m_reg_write & (r_m_rd != AW'(REG_ZERO));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid     <= 1'b0;
            r_m_reg_write <= 1'b0;
            r_m_mem_read  <= 1'b0;
            r_m_load_type <= LT_W;
            r_m_rd        <= '0;
            r_m_result    <= '0;
        end else if (!stall) begin
            r_m_valid     <= ex_valid & ~flush;
            r_m_reg_write <= ex_reg_write;
            r_m_mem_read  <= ex_mem_read;
            r_m_load_type <= ex_load_type;
            r_m_rd        <= ex_rd;
            r_m_result    <= ex_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= HS_RUN;
            r_held <= '0;
        end else begin
            case (r_hold)
                HS_RUN: begin
                    if (stall && r_m_valid && r_m_mem_read) begin
                        r_hold <= HS_HELD;
                        r_held <= dmem_rdata;
                    end
                end
                HS_HELD: begin
                    if (!stall) begin
                        r_hold <= HS_RUN;
                    end
                end
                default: r_hold <= HS_RUN;
            endcase
        end
    end

    // A stalled M must not write twice, so W takes a bubble during stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_w_we <= 1'b0;
            r_w_rd <= '0;
            r_w_wd <= '0;
        end else if (!stall) begin
            r_w_we <= w_m_fwd;
            r_w_rd <= r_m_rd;
            r_w_wd <= w_m_value;
        end else begin
            r_w_we <= 1'b0;
            r_w_rd <= '0;
            r_w_wd <= '0;
        end
    end

    assign rf_we = r_w_we;
    assign rf_wa = r_w_rd;
    assign rf_wd = r_w_wd;

    // forward_rd stays 0 whenever forward_ra is 0 so $0 reads stay 0.
    always_comb begin
        forward_ra = '0;
        forward_rd = '0;
        if (w_m_fwd) begin
            forward_ra = r_m_rd;
            forward_rd = w_m_value;
        end
`ifdef WB_FORWARD_EN
        else if (r_w_we) begin
            forward_ra = r_w_rd;
            forward_rd = r_w_wd;
        end
`endif
    end

endmodule
